hazard_stall_unit: RTL and testbench
====================================

// Module: hazard_stall_unit
// PURPOSE
//  Stall/flush controller for the 5-stage MIPS pipeline; pairs with the forwarding unit.
//  Forwarding resolves hazards by bypassing. This block covers the hazards a bypass cannot fix:
//  load-use, and branch-in-decode operand dependencies.
//  Drives PC/IF-ID write enables, the ID/EX bubble and the IF/ID flush.
//  A down-counter holds multi-cycle stalls independent of downstream pipeline contents.
// PARAMETERS
//  REG_W     32  width of register-number fields; compared full width, value 0 = $zero
//  CNT_W     16  width of optional stall statistics counter
// PORTS
//  Clk                  in   1      pipeline clock, rising edge
//  Rst                  in   1      async reset, active-low
//  Decode_RegisterRs    in   REG_W  Rs of instruction in ID
//  Decode_RegisterRt    in   REG_W  Rt of instruction in ID
//  Decode_UsesRs        in   1      ID instruction reads Rs
//  Decode_UsesRt        in   1      ID instruction reads Rt
//  Decode_Branch        in   1      ID instruction is a decode-resolved branch (beq/bne/etc.)
//  IDEX_MemRead         in   1      EX instruction is a load
//  IDEX_RegWrite        in   1      EX instruction writes a register
//  IDEX_RegDst          in   REG_W  EX destination register
//  EXMEM_MemRead        in   1      MEM instruction is a load
//  EXMEM_RegDst         in   REG_W  MEM destination register
//  Branch_Taken         in   1      branch/jump in ID resolved taken this cycle
//  PC_Write             out  1      PC update enable
//  IFID_Write           out  1      IF/ID register write enable
//  IDEX_Bubble          out  1      zero all ID/EX control bits (insert nop)
//  IFID_Flush           out  1      clear IF/ID (squash wrong-path fetch)
//  Stall_Active         out  1      any stall this cycle
//  Stall_Count          out  CNT_W  stall cycles since reset (see CONFIGURATION)
// BEHAVIOUR
//  Match rule:
//   - matchEX(r) = IDEX_RegWrite & r==IDEX_RegDst & r!=0.
//   - matchMEM(r) = EXMEM_MemRead & r==EXMEM_RegDst & r!=0.
//   - A source r counts only when its Uses* bit is 1.
//  Required stall length N, evaluated in RUN only:
//   - Decode_Branch=0 & IDEX_MemRead & matchEX(src)    -> N=1 (load-use; forwarding covers the rest)
//   - Decode_Branch=1 & IDEX_MemRead & matchEX(src)    -> N=2
//   - Decode_Branch=1 & !IDEX_MemRead & matchEX(src)   -> N=1
//   - Decode_Branch=1 & matchMEM(src)                  -> N=1
//   - Multiple rules hit -> N is the maximum; otherwise N=0.
//  FSM states: RUN, HOLD. 2-bit counter rem.
//   RUN,  N=0: PC_Write=IFID_Write=1, IDEX_Bubble=0, Stall_Active=0; IFID_Flush=Branch_Taken.
//   RUN,  N>=1: PC_Write=IFID_Write=0, IDEX_Bubble=1, Stall_Active=1 (combinational, same cycle).
//     - N=1: stay RUN.
//     - N=2: rem<=1, go HOLD.
//   HOLD: stall outputs asserted unconditionally; all hazard inputs ignored.
//     - rem<=rem-1 each cycle; go RUN when rem==1 at the clock edge (one HOLD cycle for N=2).
//  Stall beats flush: while stall asserted, IFID_Flush=0 and Branch_Taken is ignored.
//   - Branch operands are stale, so resolution is invalid.
//  Outputs are combinational from state+inputs. No extra latency beyond the stated cycles.
//  Reset (Rst=0, async):
//   - state=RUN, rem=0, Stall_Count=0.
//   - While in reset: PC_Write=IFID_Write=1, IDEX_Bubble=0, IFID_Flush=0, Stall_Active=0.
//  Reset asserted in HOLD aborts the stall immediately. The first cycle after release is RUN.
// CONFIGURATION
//  HAZ_STALL_CNT_EN defined:
//   - Stall_Count increments by 1 on every clock edge where Stall_Active=1.
//   - Saturates at all-ones; no wrap.
//  Undefined: no counter logic; Stall_Count tied to 0.
// TESTING
//  - lw r8 in EX (IDEX_MemRead=1, IDEX_RegDst=8), add reads Rs=8 in ID
//    -> 1 cycle PC_Write=0, IDEX_Bubble=1; next cycle (IDEX cleared) PC_Write=1.
//  - lw r8 in EX, beq Rs=8 in ID
//    -> 2 consecutive stall cycles even though IDEX inputs go 0 after cycle 1; third cycle RUN.
//  - addi r9 in EX (RegWrite=1, MemRead=0), beq Rt=9 in ID -> exactly 1 stall cycle.
//  - Dependency on $zero (IDEX_RegDst=0, MemRead=1, Rs=0) -> no stall.
//    - Uses* = 0 with matching regs -> no stall.
//  - Branch_Taken=1 with N=0 -> IFID_Flush=1 for one cycle.
//    - Branch_Taken=1 with load-use hit -> IFID_Flush=0, stall asserted.
//  - Rst low during HOLD -> outputs at reset values at once.
//    - With HAZ_STALL_CNT_EN: Stall_Count=0 after reset; 3 stall cycles -> 3; counter saturates.

Source files
------------

// File: rtl/hazard_stall_unit_if.sv
// Hazard stall unit bus: groups the decode/EX/MEM hazard inputs and the
// pipeline control outputs. The master modport is the pipeline side that
// supplies hazard information. The slave modport is the stall controller.
interface hazard_stall_unit_if #(
    parameter int REG_W = 32,
    parameter int CNT_W = 16
);
    logic [REG_W-1:0] Decode_RegisterRs;
    logic [REG_W-1:0] Decode_RegisterRt;
    logic             Decode_UsesRs;
    logic             Decode_UsesRt;
    logic             Decode_Branch;
    logic             IDEX_MemRead;
    logic             IDEX_RegWrite;
    logic [REG_W-1:0] IDEX_RegDst;
    logic             EXMEM_MemRead;
    logic [REG_W-1:0] EXMEM_RegDst;
    logic             Branch_Taken;

    logic             PC_Write;
    logic             IFID_Write;
    logic             IDEX_Bubble;
    logic             IFID_Flush;
    logic             Stall_Active;
    logic [CNT_W-1:0] Stall_Count;

    modport master (
        output Decode_RegisterRs, Decode_RegisterRt, Decode_UsesRs, Decode_UsesRt,
               Decode_Branch, IDEX_MemRead, IDEX_RegWrite, IDEX_RegDst,
               EXMEM_MemRead, EXMEM_RegDst, Branch_Taken,
        input  PC_Write, IFID_Write, IDEX_Bubble, IFID_Flush, Stall_Active, Stall_Count
    );

    modport slave (
        input  Decode_RegisterRs, Decode_RegisterRt, Decode_UsesRs, Decode_UsesRt,
               Decode_Branch, IDEX_MemRead, IDEX_RegWrite, IDEX_RegDst,
               EXMEM_MemRead, EXMEM_RegDst, Branch_Taken,
        output PC_Write, IFID_Write, IDEX_Bubble, IFID_Flush, Stall_Active, Stall_Count
    );
endinterface

// File: rtl/hazard_stall_unit.sv
// Stall/flush controller for a 5-stage MIPS pipeline.
// Handles the hazards that bypassing cannot fix: load-use, and operand
// dependencies of branches resolved in decode. A two-state FSM (RUN/HOLD)
// with a small down-counter keeps a two-cycle stall alive even after the
// producing instruction has moved on, so the stall length never depends on
// what flows into ID/EX behind the bubble.
// Optional feature: define HAZ_STALL_CNT_EN to enable the saturating stall
// statistics counter on Stall_Count; otherwise Stall_Count is tied to zero.
module hazard_stall_unit #(
    parameter int REG_W = 32,
    parameter int CNT_W = 16
) (
    input logic                Clk,
    input logic                Rst,
    hazard_stall_unit_if.slave hz
);

    typedef enum logic [0:0] {
        RUN  = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t     state_q, state_d;
    logic [1:0] rem_q, rem_d;

    logic       ex_rs, ex_rt, mem_rs, mem_rt;
    logic       ex_hit, mem_hit;
    logic [1:0] need_n;
    logic       stall;

    // Register-number match; register 0 ($zero) never creates a dependency.
    function automatic logic reg_match(input logic en,
                                       input logic [REG_W-1:0] r,
                                       input logic [REG_W-1:0] dst);
        return en && (r == dst) && (r != '0);
    endfunction

    // Dependency detection against the EX and MEM stage producers.
    always_comb begin
        ex_rs   = hz.Decode_UsesRs & reg_match(hz.IDEX_RegWrite, hz.Decode_RegisterRs, hz.IDEX_RegDst);
        ex_rt   = hz.Decode_UsesRt & reg_match(hz.IDEX_RegWrite, hz.Decode_RegisterRt, hz.IDEX_RegDst);
        mem_rs  = hz.Decode_UsesRs & reg_match(hz.EXMEM_MemRead, hz.Decode_RegisterRs, hz.EXMEM_RegDst);
        mem_rt  = hz.Decode_UsesRt & reg_match(hz.EXMEM_MemRead, hz.Decode_RegisterRt, hz.EXMEM_RegDst);
        ex_hit  = ex_rs | ex_rt;
        mem_hit = mem_rs | mem_rt;
    end

    // Required stall length; the longest requirement among all rules wins.
    always_comb begin
        need_n = 2'd0;
        if (hz.Decode_Branch) begin
            if (hz.IDEX_MemRead && ex_hit) begin
                need_n = 2'd2;
            end else if (ex_hit || mem_hit) begin
                need_n = 2'd1;
            end
        end else if (hz.IDEX_MemRead && ex_hit) begin
            // Plain load-use: one bubble, forwarding covers the rest.
            need_n = 2'd1;
        end
    end

    // State and remaining-stall register; reset aborts any stall in progress.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q <= RUN;
            rem_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
        end
    end

    // Next state: enter HOLD for two-cycle stalls, leave when the count runs out.
    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        case (state_q)
            RUN: begin
                if (need_n == 2'd2) begin
                    state_d = HOLD;
                    rem_d   = 2'd1;
                end else begin
                    rem_d   = 2'd0;
                end
            end
            HOLD: begin
                // Hazard inputs are ignored here; only the counter matters.
                if (rem_q <= 2'd1) begin
                    state_d = RUN;
                    rem_d   = 2'd0;
                end else begin
                    rem_d   = rem_q - 2'd1;
                end
            end
            default: begin
                state_d = RUN;
                rem_d   = 2'd0;
            end
        endcase
    end

    // Pipeline controls; a stall suppresses the flush because branch operands are stale.
    always_comb begin
        stall           = (state_q == HOLD) || (need_n != 2'd0);
        hz.PC_Write     = 1'b1;
        hz.IFID_Write   = 1'b1;
        hz.IDEX_Bubble  = 1'b0;
        hz.IFID_Flush   = 1'b0;
        hz.Stall_Active = 1'b0;
        if (Rst) begin
            hz.PC_Write     = ~stall;
            hz.IFID_Write   = ~stall;
            hz.IDEX_Bubble  = stall;
            hz.IFID_Flush   = ~stall & hz.Branch_Taken;
            hz.Stall_Active = stall;
        end
    end

`ifdef HAZ_STALL_CNT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Increment that holds at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // Next count: one more for every cycle in which a stall is asserted.
    always_comb begin
        cnt_d = cnt_q;
        if (hz.Stall_Active) begin
            cnt_d = sat_inc(cnt_q);
        end
    end

    // Stall statistics register.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign hz.Stall_Count = cnt_q;
`else
    assign hz.Stall_Count = '0;
`endif

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Testbench for hazard_stall_unit: scenario tasks drive hazard patterns,
// push the expected control outputs to a scoreboard queue and pop/compare
// them against the DUT on the falling edge.
module tb_hazard_stall_unit;

    localparam int REG_W = 32;
    localparam int CNT_W = 3;

    // Expected output vectors {PC_Write, IFID_Write, IDEX_Bubble, IFID_Flush, Stall_Active}
    localparam logic [4:0] FREE = 5'b11000;
    localparam logic [4:0] FLSH = 5'b11010;
    localparam logic [4:0] STL  = 5'b00101;

    logic Clk = 1'b0;
    logic Rst = 1'b0;

    always #5 Clk = ~Clk;

    hazard_stall_unit_if #(.REG_W(REG_W), .CNT_W(CNT_W)) bus ();

    hazard_stall_unit #(.REG_W(REG_W), .CNT_W(CNT_W)) dut (
        .Clk (Clk),
        .Rst (Rst),
        .hz  (bus.slave)
    );

    typedef struct {
        logic [31:0] rs, rt;
        logic        urs, urt, br, idmr, idrw;
        logic [31:0] iddst;
        logic        exmr;
        logic [31:0] exdst;
        logic        bt;
        logic [4:0]  exp;
    } step_t;

    typedef struct {
        string            name;
        logic [4:0]       outs;
        logic [CNT_W-1:0] cnt;
    } exp_t;

    exp_t sb[$];
    int   checks  = 0;
    int   errors  = 0;
    int   exp_cnt = 0;

    function automatic step_t mk(input logic [31:0] rs, input logic [31:0] rt,
                                 input logic urs, input logic urt, input logic br,
                                 input logic idmr, input logic idrw, input logic [31:0] iddst,
                                 input logic exmr, input logic [31:0] exdst,
                                 input logic bt, input logic [4:0] exp);
        step_t s;
        s.rs = rs; s.rt = rt; s.urs = urs; s.urt = urt; s.br = br;
        s.idmr = idmr; s.idrw = idrw; s.iddst = iddst;
        s.exmr = exmr; s.exdst = exdst; s.bt = bt; s.exp = exp;
        return s;
    endfunction

    function automatic logic [CNT_W-1:0] cur_cnt();
`ifdef HAZ_STALL_CNT_EN
        return exp_cnt[CNT_W-1:0];
`else
        return '0;
`endif
    endfunction

    // Counter model: saturating at all-ones, advanced once per stalled cycle.
    function automatic void bump(input logic stalled);
        if (stalled && exp_cnt < (1 << CNT_W) - 1) exp_cnt = exp_cnt + 1;
    endfunction

    task automatic set_inputs(input step_t s);
        bus.Decode_RegisterRs = s.rs;
        bus.Decode_RegisterRt = s.rt;
        bus.Decode_UsesRs     = s.urs;
        bus.Decode_UsesRt     = s.urt;
        bus.Decode_Branch     = s.br;
        bus.IDEX_MemRead      = s.idmr;
        bus.IDEX_RegWrite     = s.idrw;
        bus.IDEX_RegDst       = s.iddst;
        bus.EXMEM_MemRead     = s.exmr;
        bus.EXMEM_RegDst      = s.exdst;
        bus.Branch_Taken      = s.bt;
    endtask

    // Drive one cycle of stimulus just after the rising edge and record its expectation.
    task automatic apply(input string name, input step_t s);
        @(posedge Clk);
        #1;
        set_inputs(s);
        sb.push_back('{name, s.exp, cur_cnt()});
    endtask

    function automatic logic [4:0] obs();
        return {bus.PC_Write, bus.IFID_Write, bus.IDEX_Bubble, bus.IFID_Flush, bus.Stall_Active};
    endfunction

    step_t idle;

    task automatic test_reset();
        exp_t e;
        // Hazard present while in reset: outputs must still be reset values.
        set_inputs(mk(32'd8, 32'd0, 1, 0, 1, 1, 1, 32'd8, 0, 32'd0, 1, FREE));
        sb.push_back('{"reset_outputs", FREE, '0});
        #2;
        e = sb.pop_front();
        checks++;
        if (obs() !== e.outs) begin errors++; $display("FAIL %s: got %b want %b", e.name, obs(), e.outs); end
        checks++;
        if (bus.Stall_Count !== e.cnt) begin errors++; $display("FAIL %s_cnt: got %0d want %0d", e.name, bus.Stall_Count, e.cnt); end
        set_inputs(idle);
        @(negedge Clk);
        Rst = 1'b1;
    endtask

    task automatic test_load_use();
        step_t q[$];
        exp_t  e;
        q.push_back(mk(32'd8, 32'd3, 1, 1, 0, 1, 1, 32'd8, 0, 32'd0, 0, STL));
        q.push_back(idle);
        q.push_back(mk(32'd2, 32'd8, 0, 1, 0, 1, 1, 32'd8, 0, 32'd0, 0, STL));
        q.push_back(idle);
        foreach (q[i]) begin
            apply($sformatf("load_use_%0d", i), q[i]);
            @(negedge Clk);
            e = sb.pop_front();
            checks++;
            if (obs() !== e.outs) begin errors++; $display("FAIL %s: got %b want %b", e.name, obs(), e.outs); end
            checks++;
            if (bus.Stall_Count !== e.cnt) begin errors++; $display("FAIL %s_cnt: got %0d want %0d", e.name, bus.Stall_Count, e.cnt); end
            bump(e.outs[0]);
        end
    endtask

    task automatic test_branch_load();
        step_t q[$];
        exp_t  e;
        q.push_back(mk(32'd8, 32'd0, 1, 0, 1, 1, 1, 32'd8, 0, 32'd0, 0, STL));
        // HOLD: producer has left EX and Branch_Taken is raised, stall must persist.
        q.push_back(mk(32'd8, 32'd0, 1, 0, 1, 0, 0, 32'd0, 0, 32'd0, 1, STL));
        q.push_back(mk(32'd8, 32'd0, 1, 0, 1, 0, 0, 32'd0, 0, 32'd0, 0, FREE));
        foreach (q[i]) begin
            apply($sformatf("branch_load_%0d", i), q[i]);
            @(negedge Clk);
            e = sb.pop_front();
            checks++;
            if (obs() !== e.outs) begin errors++; $display("FAIL %s: got %b want %b", e.name, obs(), e.outs); end
            checks++;
            if (bus.Stall_Count !== e.cnt) begin errors++; $display("FAIL %s_cnt: got %0d want %0d", e.name, bus.Stall_Count, e.cnt); end
            bump(e.outs[0]);
        end
    endtask

    task automatic test_branch_alu_mem();
        step_t q[$];
        exp_t  e;
        q.push_back(mk(32'd1, 32'd9, 0, 1, 1, 0, 1, 32'd9, 0, 32'd0, 0, STL));
        q.push_back(mk(32'd1, 32'd9, 0, 1, 1, 0, 0, 32'd0, 0, 32'd0, 0, FREE));
        q.push_back(mk(32'd5, 32'd0, 1, 0, 1, 0, 0, 32'd0, 1, 32'd5, 0, STL));
        q.push_back(idle);
        // Non-branch consumers are covered by forwarding.
        q.push_back(mk(32'd5, 32'd0, 1, 0, 0, 0, 0, 32'd0, 1, 32'd5, 0, FREE));
        q.push_back(mk(32'd9, 32'd0, 1, 0, 0, 0, 1, 32'd9, 0, 32'd0, 0, FREE));
        foreach (q[i]) begin
            apply($sformatf("branch_alu_mem_%0d", i), q[i]);
            @(negedge Clk);
            e = sb.pop_front();
            checks++;
            if (obs() !== e.outs) begin errors++; $display("FAIL %s: got %b want %b", e.name, obs(), e.outs); end
            checks++;
            if (bus.Stall_Count !== e.cnt) begin errors++; $display("FAIL %s_cnt: got %0d want %0d", e.name, bus.Stall_Count, e.cnt); end
            bump(e.outs[0]);
        end
    endtask

    task automatic test_no_stall_cases();
        step_t q[$];
        exp_t  e;
        q.push_back(mk(32'd0, 32'd0, 1, 1, 1, 1, 1, 32'd0, 1, 32'd0, 0, FREE));
        q.push_back(mk(32'd8, 32'd8, 0, 0, 1, 1, 1, 32'd8, 1, 32'd8, 0, FREE));
        q.push_back(mk(32'h80000008, 32'd0, 1, 0, 0, 1, 1, 32'd8, 0, 32'd0, 0, FREE));
        q.push_back(mk(32'd8, 32'd0, 1, 0, 0, 1, 0, 32'd8, 0, 32'd0, 0, FREE));
        foreach (q[i]) begin
            apply($sformatf("no_stall_%0d", i), q[i]);
            @(negedge Clk);
            e = sb.pop_front();
            checks++;
            if (obs() !== e.outs) begin errors++; $display("FAIL %s: got %b want %b", e.name, obs(), e.outs); end
            checks++;
            if (bus.Stall_Count !== e.cnt) begin errors++; $display("FAIL %s_cnt: got %0d want %0d", e.name, bus.Stall_Count, e.cnt); end
            bump(e.outs[0]);
        end
    endtask

    task automatic test_flush();
        step_t q[$];
        exp_t  e;
        q.push_back(mk(32'd4, 32'd0, 1, 0, 1, 0, 0, 32'd0, 0, 32'd0, 1, FLSH));
        q.push_back(idle);
        q.push_back(mk(32'd8, 32'd0, 1, 0, 0, 1, 1, 32'd8, 0, 32'd0, 1, STL));
        q.push_back(idle);
        foreach (q[i]) begin
            apply($sformatf("flush_%0d", i), q[i]);
            @(negedge Clk);
            e = sb.pop_front();
            checks++;
            if (obs() !== e.outs) begin errors++; $display("FAIL %s: got %b want %b", e.name, obs(), e.outs); end
            checks++;
            if (bus.Stall_Count !== e.cnt) begin errors++; $display("FAIL %s_cnt: got %0d want %0d", e.name, bus.Stall_Count, e.cnt); end
            bump(e.outs[0]);
        end
    endtask

    task automatic test_back_to_back();
        step_t q[$];
        exp_t  e;
        step_t br_lw;
        br_lw = mk(32'd0, 32'd7, 0, 1, 1, 1, 1, 32'd7, 0, 32'd0, 0, STL);
        q.push_back(br_lw);
        q.push_back(br_lw);
        q.push_back(br_lw);
        q.push_back(br_lw);
        q.push_back(mk(32'd0, 32'd7, 0, 1, 1, 0, 0, 32'd0, 0, 32'd0, 1, FLSH));
        q.push_back(idle);
        foreach (q[i]) begin
            apply($sformatf("back_to_back_%0d", i), q[i]);
            @(negedge Clk);
            e = sb.pop_front();
            checks++;
            if (obs() !== e.outs) begin errors++; $display("FAIL %s: got %b want %b", e.name, obs(), e.outs); end
            checks++;
            if (bus.Stall_Count !== e.cnt) begin errors++; $display("FAIL %s_cnt: got %0d want %0d", e.name, bus.Stall_Count, e.cnt); end
            bump(e.outs[0]);
        end
    endtask

    task automatic test_reset_in_hold();
        step_t q[$];
        exp_t  e;
        apply("rst_hold_enter", mk(32'd8, 32'd0, 1, 0, 1, 1, 1, 32'd8, 0, 32'd0, 0, STL));
        @(negedge Clk);
        e = sb.pop_front();
        checks++;
        if (obs() !== e.outs) begin errors++; $display("FAIL %s: got %b want %b", e.name, obs(), e.outs); end
        bump(e.outs[0]);
        // Now in HOLD with no hazard inputs.
        @(posedge Clk);
        #1;
        set_inputs(idle);
        sb.push_back('{"rst_hold_in_hold", STL, cur_cnt()});
        #1;
        e = sb.pop_front();
        checks++;
        if (obs() !== e.outs) begin errors++; $display("FAIL %s: got %b want %b", e.name, obs(), e.outs); end
        // Reset in the middle of HOLD with a hazard present.
        set_inputs(mk(32'd8, 32'd0, 1, 0, 1, 1, 1, 32'd8, 0, 32'd0, 1, FREE));
        Rst = 1'b0;
        exp_cnt = 0;
        sb.push_back('{"rst_hold_abort", FREE, cur_cnt()});
        #1;
        e = sb.pop_front();
        checks++;
        if (obs() !== e.outs) begin errors++; $display("FAIL %s: got %b want %b", e.name, obs(), e.outs); end
        checks++;
        if (bus.Stall_Count !== e.cnt) begin errors++; $display("FAIL %s_cnt: got %0d want %0d", e.name, bus.Stall_Count, e.cnt); end
        @(negedge Clk);
        set_inputs(idle);
        @(negedge Clk);
        Rst = 1'b1;
        q.push_back(idle);
        q.push_back(mk(32'd8, 32'd0, 1, 0, 0, 1, 1, 32'd8, 0, 32'd0, 0, STL));
        q.push_back(mk(32'd8, 32'd0, 1, 0, 0, 1, 1, 32'd8, 0, 32'd0, 0, STL));
        q.push_back(mk(32'd8, 32'd0, 1, 0, 0, 1, 1, 32'd8, 0, 32'd0, 0, STL));
        q.push_back(idle);
        foreach (q[i]) begin
            apply($sformatf("rst_hold_after_%0d", i), q[i]);
            @(negedge Clk);
            e = sb.pop_front();
            checks++;
            if (obs() !== e.outs) begin errors++; $display("FAIL %s: got %b want %b", e.name, obs(), e.outs); end
            checks++;
            if (bus.Stall_Count !== e.cnt) begin errors++; $display("FAIL %s_cnt: got %0d want %0d", e.name, bus.Stall_Count, e.cnt); end
            bump(e.outs[0]);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, limit 200000", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        idle = mk(32'd0, 32'd0, 0, 0, 0, 0, 0, 32'd0, 0, 32'd0, 0, FREE);
        set_inputs(idle);
        test_reset();
        test_load_use();
        test_branch_load();
        test_branch_alu_mem();
        test_no_stall_cases();
        test_flush();
        test_back_to_back();
        test_reset_in_hold();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
